// File: rtl/fact_controller_pkg.sv
// Shared types and constants for the factorial controller and its multiplier.
package fact_controller_pkg;

    // Controller sequence; one state per register-file operation.
    typedef enum logic [3:0] {
        StIdle,
        StInitN,
        StInitAcc,
        StInitCnt,
        StCheck,
        StMul,
        StWrAcc,
        StDec,
        StDone
    } state_e;

    // Register file allocation.
    localparam logic [1:0] REG_T0 = 2'b00;  // down-counter i
    localparam logic [1:0] REG_T1 = 2'b01;  // unused
    localparam logic [1:0] REG_S0 = 2'b10;  // accumulator
    localparam logic [1:0] REG_S1 = 2'b11;  // copy of n

    // Shift-add multiplier length: one step per multiplier bit.
    localparam int unsigned MUL_STEPS = 8;

endpackage

// File: rtl/fact_controller_mul8_seq.sv
// Sequential 8x8 shift-add multiplier with a fixed 8-step run phase.
// product_o shows the accumulator including the step taken this cycle, so
// valid_o and the final product are visible during the last run cycle.
module mul8_seq
    import fact_controller_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        run_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] product_o,
    output logic        valid_o
);

    localparam logic [3:0] StepLast = 4'(MUL_STEPS - 1);

    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;

    // Load operands, or take one shift-add step per run cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = {8'h00, a_i};
            mplier_d = b_i;
            acc_d    = 16'h0000;
            cnt_d    = 4'd0;
        end else if (run_i && (cnt_q <= StepLast)) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 4'd1;
        end
    end

    // Multiplier state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            acc_q    <= 16'h0000;
            cnt_q    <= 4'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product_o = acc_d;
    assign valid_o   = run_i && !load_i && (cnt_q == StepLast);

endmodule

// File: rtl/fact_controller.sv
// Factorial controller: drives an external 4x8 register file and a sequential
// multiplier to compute n! in 8 bits, flagging overflow past 255.
module fact_controller
    import fact_controller_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] n,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic [7:0] result,
    output logic [1:0] rf_read1,
    output logic [1:0] rf_read2,
    output logic [1:0] rf_regesc,
    output logic [7:0] rf_dadoescr,
    output logic       rf_escreg,
    input  logic [7:0] rf_data1,
    input  logic [7:0] rf_data2
);

    state_e      state_q, state_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  result_q, result_d;
    logic        ovf_q, ovf_d;

    logic        mul_load;
    logic        mul_run;
    logic        mul_valid;
    logic [15:0] mul_product;

    mul8_seq u_mul (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (mul_load),
        .run_i     (mul_run),
        .a_i       (rf_data1),
        .b_i       (rf_data2),
        .product_o (mul_product),
        .valid_o   (mul_valid)
    );

    // Next-state, register-file control and result capture.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        mul_load    = 1'b0;
        mul_run     = 1'b0;
        rf_read1    = 2'b00;
        rf_read2    = 2'b00;
        rf_regesc   = 2'b00;
        rf_dadoescr = 8'h00;
        rf_escreg   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_d      = n;
                    result_d = 8'h00;
                    ovf_d    = 1'b0;
                    state_d  = StInitN;
                end
            end
            StInitN: begin
                rf_escreg   = 1'b1;
                rf_regesc   = REG_S1;
                rf_dadoescr = n_q;
                state_d     = StInitAcc;
            end
            StInitAcc: begin
                rf_escreg   = 1'b1;
                rf_regesc   = REG_S0;
                rf_dadoescr = 8'd1;
                state_d     = StInitCnt;
            end
            StInitCnt: begin
                rf_escreg   = 1'b1;
                rf_regesc   = REG_T0;
                rf_dadoescr = n_q;
                state_d     = StCheck;
            end
            StCheck: begin
                rf_read1 = REG_S0;
                rf_read2 = REG_T0;
                if (rf_data2 <= 8'd1) begin
                    result_d = rf_data1;
                    ovf_d    = 1'b0;
                    state_d  = StDone;
                end else begin
                    // Multiplier latches s0 and t0 as its operands.
                    mul_load = 1'b1;
                    state_d  = StMul;
                end
            end
            StMul: begin
                mul_run = 1'b1;
                if (mul_valid) begin
                    if (mul_product[15:8] != 8'h00) begin
                        result_d = 8'h00;
                        ovf_d    = 1'b1;
                        state_d  = StDone;
                    end else begin
                        state_d = StWrAcc;
                    end
                end
            end
            StWrAcc: begin
                rf_escreg   = 1'b1;
                rf_regesc   = REG_S0;
                rf_dadoescr = mul_product[7:0];
                state_d     = StDec;
            end
            StDec: begin
                rf_read2    = REG_T0;
                rf_escreg   = 1'b1;
                rf_regesc   = REG_T0;
                rf_dadoescr = rf_data2 - 8'd1;
                state_d     = StCheck;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset wins over any start in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            n_q      <= 8'h00;
            result_q <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != StIdle) && (state_q != StDone);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_fact_controller.sv
// Self-checking bench for fact_controller with an attached 4x8 register file.
module tb_fact_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] n = 8'h00;
    logic       busy, done, ovf, rf_escreg;
    logic [7:0] result, rf_dadoescr, rf_data1, rf_data2;
    logic [1:0] rf_read1, rf_read2, rf_regesc;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    bit prev_done = 1'b0;
    bit rf_fill  = 1'b1;

    logic [7:0] rf [4];

    fact_controller dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .n           (n),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf),
        .result      (result),
        .rf_read1    (rf_read1),
        .rf_read2    (rf_read2),
        .rf_regesc   (rf_regesc),
        .rf_dadoescr (rf_dadoescr),
        .rf_escreg   (rf_escreg),
        .rf_data1    (rf_data1),
        .rf_data2    (rf_data2)
    );

    always #5 clock = ~clock;

    // Register file: combinational reads, synchronous write, never reset.
    always @(posedge clock) begin
        if (rf_fill) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'hA5;
        end else if (rf_escreg) begin
            rf[rf_regesc] <= rf_dadoescr;
        end
    end
    assign rf_data1 = rf[rf_read1];
    assign rf_data2 = rf[rf_read2];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Per-cycle protocol checks.
    always @(negedge clock) begin
        if (!reset) begin
            check("proto_done_not_busy", int'(done && busy), 0);
            check("proto_done_single", int'(done && prev_done), 0);
            check("proto_wr_only_busy", int'(rf_escreg && !busy), 0);
            check("proto_no_x", int'($isunknown({rf_regesc, rf_dadoescr, rf_read1, rf_read2})), 0);
            if (rf_escreg) wr_cnt++;
        end
        prev_done = done;
    end

    // Reference: factorial with 8-bit overflow, cycle count from the step costs.
    function automatic void model(input int nn, output int res, output bit ov, output int lat,
                                  output int wr, output int t0f, output int s0f);
        int acc;
        int iters;
        acc = 1;
        iters = 0;
        ov = 1'b0;
        t0f = nn;
        if (nn <= 1) begin
            res = 1; lat = 4; wr = 3; s0f = 1;
            return;
        end
        for (int i = nn; i >= 2; i--) begin
            if (acc * i > 255) begin
                ov = 1'b1; res = 0; lat = 3 + 11 * iters + 9; wr = 3 + 2 * iters;
                t0f = i; s0f = acc;
                return;
            end
            acc = acc * i;
            iters++;
        end
        res = acc; lat = 3 + 11 * iters + 1; wr = 3 + 2 * iters; t0f = 1; s0f = acc;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_escreg"}, int'(rf_escreg), 0);
        check({tag, "_read1"}, int'(rf_read1), 0);
        check({tag, "_read2"}, int'(rf_read2), 0);
        check({tag, "_regesc"}, int'(rf_regesc), 0);
        check({tag, "_dadoescr"}, int'(rf_dadoescr), 0);
    endtask

    // Start a run and wait for done; noise keeps start high with n=3 while busy.
    task automatic run_op(input logic [7:0] nn, input bit noise, output int lat);
        @(negedge clock);
        start = 1'b1;
        n = nn;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 8'($urandom);
        wr_cnt = 0;
        lat = 0;
        while (lat < 300) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (done) break;
            if (noise) begin
                start = 1'b1;
                n = 8'd3;
            end
        end
        start = 1'b0;
        if (!done) begin
            check("run_timeout", lat, -1);
        end
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] nn, input int exp_res,
                                 input bit exp_ovf, input int exp_lat, input bit noise);
        int lat, m_res, m_lat, m_wr, m_t0, m_s0;
        bit m_ovf;
        model(int'(nn), m_res, m_ovf, m_lat, m_wr, m_t0, m_s0);
        run_op(nn, noise, lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, int'(result), exp_res);
        check({tag, "_ovf"}, int'(ovf), int'(exp_ovf));
        check({tag, "_writes"}, wr_cnt, m_wr);
        check({tag, "_rf_s0"}, int'(rf[2]), m_s0);
        check({tag, "_rf_s1"}, int'(rf[3]), int'(nn));
        check({tag, "_rf_t0"}, int'(rf[0]), m_t0);
    endtask

    typedef struct {
        logic [7:0] n;
        int         res;
        bit         ovf;
        int         lat;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   lat, dcount;
        int   m_res, m_lat, m_wr, m_t0, m_s0;
        bit   m_ovf;
        logic [7:0] rn;

        vecs[0] = '{n: 8'd5, res: 120, ovf: 1'b0, lat: 48};
        vecs[1] = '{n: 8'd0, res: 1,   ovf: 1'b0, lat: 4};
        vecs[2] = '{n: 8'd1, res: 1,   ovf: 1'b0, lat: 4};
        vecs[3] = '{n: 8'd6, res: 0,   ovf: 1'b1, lat: 45};
        vecs[4] = '{n: 8'd2, res: 2,   ovf: 1'b0, lat: 15};
        vecs[5] = '{n: 8'd3, res: 6,   ovf: 1'b0, lat: 26};
        vecs[6] = '{n: 8'd4, res: 24,  ovf: 1'b0, lat: 37};

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        rf_fill = 1'b0;
        check_outputs_zero("reset");
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_and_check($sformatf("vec_n%0d", vecs[i].n), vecs[i].n, vecs[i].res,
                          vecs[i].ovf, vecs[i].lat, 1'b0);
        end
        // After n=6 the last good accumulator write was 120.
        run_and_check("ovf_n6_again", 8'd6, 0, 1'b1, 45, 1'b0);
        check("ovf_n6_last_s0", int'(rf[2]), 120);

        // Start held while busy with n=3 during an n=4 run is ignored.
        run_and_check("busy_start", 8'd4, 24, 1'b0, 37, 1'b1);
        dcount = 0;
        repeat (60) begin
            @(negedge clock);
            if (done) dcount++;
        end
        check("busy_start_no_second_done", dcount, 0);
        check("busy_start_result_held", int'(result), 24);

        // Reset in the middle of MUL during n=5.
        @(negedge clock);
        start = 1'b1;
        n = 8'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clock);
        check("midreset_busy_before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        check_outputs_zero("midreset");
        reset = 1'b0;
        check("midreset_rf_kept_s1", int'(rf[3]), 5);
        run_and_check("after_reset_n4", 8'd4, 24, 1'b0, 37, 1'b0);

        // Reset beats start in the same cycle.
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        n = 8'd2;
        @(negedge clock);
        check("reset_priority_busy", int'(busy), 0);
        reset = 1'b0;
        start = 1'b0;

        // Random operands against the reference model.
        for (int k = 0; k < 20; k++) begin
            rn = (k % 4 == 3) ? 8'($urandom) : 8'($urandom_range(0, 9));
            model(int'(rn), m_res, m_ovf, m_lat, m_wr, m_t0, m_s0);
            run_and_check($sformatf("rand%0d_n%0d", k, rn), rn, m_res, m_ovf, m_lat, 1'b0);
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fact_controller.md
FACT_CONTROLLER -- requirements
Module: fact_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  request a factorial; sampled in IDLE only
- n  in  8  operand; captured when start is accepted
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse in DONE
- ovf  out  1  valid with done; 1 = result exceeded 255
- result  out  8  valid with done; n! or 8'h00 on overflow
- rf_read1  out  2  register file read address 1
- rf_read2  out  2  register file read address 2
- rf_regesc  out  2  register file write address
- rf_dadoescr  out  8  register file write data
- rf_escreg  out  1  register file write enable
- rf_data1  in  8  register file read data 1 (combinational)
- rf_data2  in  8  register file read data 2 (combinational)

Function
REQ-003 Register allocation SHALL be: t0 (2'b00) = down-counter i; t1 (2'b01) = unused; s0 (2'b10) = accumulator; s1 (2'b11) = copy of n.
REQ-004 FSM states SHALL be IDLE, INIT_N, INIT_ACC, INIT_CNT, CHECK, MUL, WR_ACC, DEC, DONE.
REQ-005 IDLE -> INIT_N on start=1, latching n; start in any other state SHALL be ignored.
REQ-006 Initialisation writes, one per state, one cycle each:
- INIT_N: s1 <= n
- INIT_ACC: s0 <= 1
- INIT_CNT: t0 <= n
- Next state after INIT_CNT: CHECK.
REQ-007 CHECK SHALL read t0 on rf_read2.
- If rf_data2 <= 1: go to DONE, and result SHALL be s0 read on rf_read1 and registered on that edge.
- Otherwise: capture rf_data1 (s0) and rf_data2 (t0) into local operand registers and go to MUL.
REQ-008 MUL SHALL last exactly 8 cycles of shift-add, producing a 16-bit product of the captured operands.
REQ-009 At the end of MUL:
- If product[15:8] != 0: go to DONE with ovf=1 and result=8'h00.
- Otherwise: go to WR_ACC.
REQ-010 WR_ACC SHALL write s0 <= product[7:0], then go to DEC.
REQ-011 DEC SHALL write t0 <= t0 - 1 (t0 read combinationally in the same cycle), then go to CHECK.
REQ-012 rf_escreg SHALL be high only in INIT_N, INIT_ACC, INIT_CNT, WR_ACC and DEC.
- rf_regesc and rf_dadoescr are don't-care when rf_escreg is low but SHALL NOT be X.
REQ-013 DONE SHALL last one cycle with done=1, then return to IDLE.
- result and ovf SHALL hold their values until the next accepted start.
REQ-014 Latency from the edge that accepts start to the cycle done is high:
- n in {0,1}: 4 cycles.
- n >= 2 without overflow: 11n-7 cycles.
REQ-015 n=0 and n=1 SHALL both return result=1, ovf=0.
- Largest non-overflowing input is n=5 (120); any n >= 6 SHALL return ovf=1.
REQ-016 The counter SHALL never wrap: CHECK terminates at t0 <= 1 before any decrement below 1.

Reset
REQ-017 Reset SHALL force state IDLE and clear busy, done, ovf, result, rf_escreg, rf_read1, rf_read2, rf_regesc and rf_dadoescr to 0.
- The same applies when reset arrives mid-operation.
REQ-018 Register file contents SHALL NOT be cleared by this block.
- After reset, the next start re-initialises s0, s1 and t0 before use.
REQ-019 Reset SHALL take priority over start in the same cycle.

Structure
REQ-020 A shared package SHALL hold:
- the state enum
- register address constants REG_T0, REG_T1, REG_S0, REG_S1
- MUL_STEPS = 8
REQ-021 The shift-add multiplier SHALL be a sub-module, mul8_seq: load/run inputs, 8-cycle fixed latency, 16-bit product, product-valid flag.
REQ-022 The controller SHALL instantiate no register file.
- The testbench connects the controller to the existing 4x8 register file.

Verification
REQ-023 Reset; start with n=5 -> done after 48 cycles, result=120, ovf=0; s0=120, s1=5, t0=1 in the register file.
REQ-024 start with n=0, then n=1 -> each completes in 4 cycles with result=1, ovf=0.
REQ-025 start with n=6 -> done with ovf=1, result=8'h00; last successful write to s0 is 120.
REQ-026 start pulsed again while busy with n=3 during an n=4 run -> ignored; result=24, and a second done does not occur.
REQ-027 Reset asserted in MUL during n=5 -> next cycle IDLE, all outputs 0; a following start with n=4 gives result=24 after 37 cycles.
REQ-028 Protocol check on every cycle: rf_escreg is high only in the states listed in REQ-012, done is a single-cycle pulse, and busy=0 whenever done=1.
